// File: rtl/game_sequencer.sv
// Game sequencer: physics tick generation, platform scan / landing detection,
// score keeping and the IDLE/RUN/OVER game flow.
module game_sequencer #(
  parameter int SCREEN_HEIGHT = 700,
  parameter int BLOCK_WIDTH   = 40,
  parameter int BLOCK_HEIGHT  = 5,
  parameter int DOODLE_WIDTH  = 20,
  parameter int NUM_BLOCKS    = 8,
  parameter int TICK_DIV      = 16,
  parameter int SCROLL_LINE   = 400
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [31:0]                   doodleX,
  input  logic [31:0]                   doodleY,
  input  logic                          falling,
  output logic [$clog2(NUM_BLOCKS)-1:0] blockIdx,
  input  logic [31:0]                   blockX,
  input  logic [31:0]                   blockY,
  output logic                          physicsUpdate,
  output logic                          hasCollide,
  output logic                          doodleReset,
  output logic                          scrollEn,
  output logic [15:0]                   score,
  output logic                          gameOver
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = $clog2(NUM_BLOCKS);

  if (TICK_DIV < NUM_BLOCKS + 2 || SCROLL_LINE >= SCREEN_HEIGHT ||
      (NUM_BLOCKS & (NUM_BLOCKS - 1)) != 0) begin : g_param_check
    $error("game_sequencer: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tick_cnt, tick_nxt;
  logic               acc, acc_nxt;
  logic               collide_q, collide_nxt;
  logic [15:0]        score_q, score_nxt;

  logic               tick_zero;
  logic               in_scan;
  logic               scan_end;
  logic               match;
  logic               scan_hit;

  assign tick_zero = (tick_cnt == '0);
  assign in_scan   = !tick_zero && (tick_cnt <= CNT_W'(NUM_BLOCKS));
  assign scan_end  = (tick_cnt == CNT_W'(NUM_BLOCKS));

  // Landing test: doodle bottom rests exactly on the platform top and the
  // horizontal extents overlap (open intervals, 32-bit unsigned arithmetic).
  assign match = falling
              && (doodleY == blockY + 32'(BLOCK_HEIGHT))
              && (doodleX + 32'(DOODLE_WIDTH) > blockX)
              && (doodleX < blockX + 32'(BLOCK_WIDTH));

  assign scan_hit = acc | match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      acc       <= 1'b0;
      collide_q <= 1'b0;
      score_q   <= '0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      acc       <= acc_nxt;
      collide_q <= collide_nxt;
      score_q   <= score_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tick_nxt    = '0;
    acc_nxt     = acc;
    collide_nxt = collide_q;
    score_nxt   = score_q;

    unique case (state)
      IDLE: begin
        collide_nxt = 1'b0;
        if (start) begin
          state_nxt = RUN;
          score_nxt = '0;
          acc_nxt   = 1'b0;
        end
      end

      RUN: begin
        tick_nxt = (tick_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : tick_cnt + CNT_W'(1);
        if (tick_zero) begin
          acc_nxt     = 1'b0;
          collide_nxt = 1'b0;
        end else if (in_scan) begin
          acc_nxt = scan_hit;
        end
        // The last table entry is still being presented on this edge, so
        // the verdict folds in the live match rather than the accumulator alone.
        if (scan_end) begin
          collide_nxt = scan_hit;
          if (scan_hit) begin
            if (score_q != 16'hFFFF) score_nxt = score_q + 16'd1;
          end else if (falling && doodleY == '0) begin
            state_nxt = OVER;
            tick_nxt  = '0;
          end
        end
      end

      OVER: begin
        collide_nxt = 1'b0;
        if (start) state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign physicsUpdate = (state == RUN) && tick_zero;
  assign scrollEn      = physicsUpdate && (doodleY > 32'(SCROLL_LINE));
  assign blockIdx      = in_scan ? IDX_W'(tick_cnt - CNT_W'(1)) : '0;
  assign hasCollide    = collide_q;
  assign score         = score_q;
  assign doodleReset   = (state == IDLE);
  assign gameOver      = (state == OVER);

endmodule
